// File: rtl/echo_width_meter.sv
// Echo pulse width meter for an ultrasonic ranger.
// Armed by the trigger generator, times the echo high time in microseconds, converts it to
// whole centimetres and publishes the result with a one-cycle valid strobe. A missing echo
// and an echo that runs past the range limit are flagged alongside the distance.
module echo_width_meter #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned US_PER_CM       = 58,
    parameter int unsigned RISE_TIMEOUT_US = 30000,
    parameter int unsigned MAX_ECHO_US     = 25000,
    parameter int unsigned DW              = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          arm,
    input  logic          echo,
    output logic [DW-1:0] dist_cm,
    output logic          dist_valid,
    output logic          busy,
    output logic          no_echo,
    output logic          over_range
);

    // Clocks per microsecond and the counter widths derived from it.
    localparam int unsigned DIV     = CLK_HZ / 1_000_000;
    localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_MAX = (RISE_TIMEOUT_US > MAX_ECHO_US) ?
                                      RISE_TIMEOUT_US : MAX_ECHO_US;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned OVER_CM = MAX_ECHO_US / US_PER_CM;

    typedef enum logic [1:0] {
        StIdle,
        StWaitRise,
        StMeasure,
        StDone
    } state_t;

    state_t          state_q, state_d;

    // Echo synchroniser and edge detector.
    logic            echo_meta_q;
    logic            echo_sync_q;
    logic            echo_prev_q;
    logic            echo_rise;
    logic            echo_fall;

    // Microsecond prescaler.
    logic [PW-1:0]   presc_q;
    logic            presc_clr;
    logic            tick;

    // Measurement counters.
    logic [CW-1:0]   us_q, us_d;
    logic [CW-1:0]   sub_q, sub_d;
    logic [CW-1:0]   cm_q, cm_d;

    // Result captured on entry to DONE, published on leaving it.
    logic [CW-1:0]   res_q, res_d;
    logic            res_ne_q, res_ne_d;
    logic            res_or_q, res_or_d;
    logic [DW-1:0]   res_sat;

    // Output registers.
    logic [DW-1:0]   dist_q;
    logic            valid_q;
    logic            ne_q;
    logic            or_q;

    assign echo_rise = echo_sync_q & ~echo_prev_q;
    assign echo_fall = ~echo_sync_q & echo_prev_q;
    assign tick      = (presc_q == PW'(DIV - 1));

    // Clamp the result into dist_cm; only matters when DW is narrower than the counters.
    generate
        if (CW > DW) begin : g_sat
            assign res_sat = (res_q > CW'({DW{1'b1}})) ? {DW{1'b1}} : res_q[DW-1:0];
        end else begin : g_nosat
            assign res_sat = DW'(res_q);
        end
    endgenerate

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    // Free-running microsecond prescaler, realigned on arm and on the echo rise.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_q <= '0;
        end else if (presc_clr || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // State, counter and captured-result registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= StIdle;
            us_q     <= '0;
            sub_q    <= '0;
            cm_q     <= '0;
            res_q    <= '0;
            res_ne_q <= 1'b0;
            res_or_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            us_q     <= us_d;
            sub_q    <= sub_d;
            cm_q     <= cm_d;
            res_q    <= res_d;
            res_ne_q <= res_ne_d;
            res_or_q <= res_or_d;
        end
    end

    // Next-state logic: arm, wait for the echo edge, count microseconds and centimetres.
    always_comb begin
        state_d   = state_q;
        us_d      = us_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        res_d     = res_q;
        res_ne_d  = res_ne_q;
        res_or_d  = res_or_q;
        presc_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d   = StWaitRise;
                    presc_clr = 1'b1;
                    us_d      = '0;
                    sub_d     = '0;
                    cm_d      = '0;
                end
            end

            StWaitRise: begin
                if (tick) begin
                    us_d = us_q + CW'(1);
                end
                // A level already high at arm never produces a rise here.
                if (echo_rise) begin
                    state_d   = StMeasure;
                    presc_clr = 1'b1;
                    us_d      = '0;
                    sub_d     = '0;
                    cm_d      = '0;
                end else if (tick && (us_q == CW'(RISE_TIMEOUT_US - 1))) begin
                    state_d  = StDone;
                    res_d    = '0;
                    res_ne_d = 1'b1;
                    res_or_d = 1'b0;
                end
            end

            StMeasure: begin
                if (tick) begin
                    us_d = us_q + CW'(1);
                    if (sub_q == CW'(US_PER_CM - 1)) begin
                        sub_d = '0;
                        cm_d  = cm_q + CW'(1);
                    end else begin
                        sub_d = sub_q + CW'(1);
                    end
                end
                // The microsecond that ends on the fall cycle still counts toward the result.
                if (echo_fall) begin
                    state_d  = StDone;
                    res_d    = cm_d;
                    res_ne_d = 1'b0;
                    res_or_d = 1'b0;
                end else if (tick && (us_q == CW'(MAX_ECHO_US - 1))) begin
                    state_d  = StDone;
                    res_d    = CW'(OVER_CM);
                    res_ne_d = 1'b0;
                    res_or_d = 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Publish the captured result as DONE ends; the strobe lasts exactly one cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dist_q  <= '0;
            valid_q <= 1'b0;
            ne_q    <= 1'b0;
            or_q    <= 1'b0;
        end else begin
            valid_q <= (state_q == StDone);
            if (state_q == StDone) begin
                dist_q <= res_sat;
                ne_q   <= res_ne_q;
                or_q   <= res_or_q;
            end
        end
    end

    assign busy       = (state_q != StIdle);
    assign dist_cm    = dist_q;
    assign dist_valid = valid_q;
    assign no_echo    = ne_q;
    assign over_range = or_q;

endmodule

// File: tb/tb_echo_width_meter.sv
// Bench for echo_width_meter: directed scenarios with hand-computed results plus randomized
// traffic, all checked cycle by cycle against a timestamp-based reference model.
module tb_echo_width_meter;

    localparam int unsigned CLK_HZ = 3_000_000;
    localparam int          DIV    = 3;
    localparam int          UPC    = 58;
    localparam int          TO     = 1500;
    localparam int          MAXUS  = 1300;
    localparam int unsigned DW     = 16;

    logic          clk  = 1'b0;
    logic          clr  = 1'b1;
    logic          arm  = 1'b0;
    logic          echo = 1'b0;
    logic [DW-1:0] dist_cm;
    logic          dist_valid;
    logic          busy;
    logic          no_echo;
    logic          over_range;

    echo_width_meter #(
        .CLK_HZ         (CLK_HZ),
        .US_PER_CM      (UPC),
        .RISE_TIMEOUT_US(TO),
        .MAX_ECHO_US    (MAXUS),
        .DW             (DW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .arm       (arm),
        .echo      (echo),
        .dist_cm   (dist_cm),
        .dist_valid(dist_valid),
        .busy      (busy),
        .no_echo   (no_echo),
        .over_range(over_range)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    // Reference model: phases with timestamps; widths come from elapsed cycles.
    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_MEAS = 2;
    localparam int PH_DONE = 3;

    int mcyc  = 0;
    int ph    = PH_IDLE;
    int t0    = 0;
    int m_res = 0;
    bit m_ne  = 1'b0;
    bit m_or  = 1'b0;
    bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;   // pin as sampled 1, 2, 3 edges ago
    bit m_rise, m_fall;
    bit e_valid = 1'b0, e_busy = 1'b0, e_ne = 1'b0, e_or = 1'b0;
    int e_dist  = 0;

    initial begin
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                ph = PH_IDLE; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
                e_valid = 1'b0; e_busy = 1'b0; e_ne = 1'b0; e_or = 1'b0; e_dist = 0;
            end else begin
                mcyc++;
                // An edge at the pin acts on the state three edges after it is first sampled.
                m_rise = h2 && !h3;
                m_fall = !h2 && h3;
                e_valid = 1'b0;
                case (ph)
                    PH_DONE: begin
                        e_valid = 1'b1; e_dist = m_res; e_ne = m_ne; e_or = m_or;
                        ph = PH_IDLE;
                    end
                    PH_IDLE: if (arm) begin ph = PH_WAIT; t0 = mcyc; end
                    PH_WAIT: begin
                        if (m_rise) begin
                            ph = PH_MEAS; t0 = mcyc;
                        end else if (mcyc - t0 == TO * DIV) begin
                            ph = PH_DONE; m_res = 0; m_ne = 1'b1; m_or = 1'b0;
                        end
                    end
                    default: begin
                        if (m_fall) begin
                            ph = PH_DONE; m_res = ((mcyc - t0) / DIV) / UPC;
                            m_ne = 1'b0; m_or = 1'b0;
                        end else if (mcyc - t0 == MAXUS * DIV) begin
                            ph = PH_DONE; m_res = MAXUS / UPC; m_ne = 1'b0; m_or = 1'b1;
                        end
                    end
                endcase
                e_busy = (ph != PH_IDLE);
                h3 = h2; h2 = h1; h1 = echo;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_cmp++;
                if (dist_valid !== e_valid || busy !== e_busy || no_echo !== e_ne ||
                    over_range !== e_or || dist_cm !== DW'(e_dist)) begin
                    n_err++;
                    $display("FAIL model t=%0t: valid/busy/ne/or/dist got %b%b%b%b/%0d want %b%b%b%b/%0d",
                             $time, dist_valid, busy, no_echo, over_range, dist_cm,
                             e_valid, e_busy, e_ne, e_or, e_dist);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // Steps until dist_valid is seen; k is the step count, or -1 if the bound expired.
    task automatic wait_valid(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (dist_valid === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (dist_valid === 1'b1) c++;
        end
    endtask

    task automatic echo_meas(input int pre_us, input int w_us, output int k);
        repeat (pre_us * DIV) step();
        echo = 1'b1;
        repeat (w_us * DIV) step();
        echo = 1'b0;
        wait_valid(20, k);
    endtask

    int k, c1, c2;
    int pre, w, ev_at;
    bit ex_arm, do_rst, idle_p;

    initial begin
        #2;
        clr    = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_valid", int'(dist_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_dist", int'(dist_cm), 0);
        check("reset_flags", int'({no_echo, over_range}), 0);
        repeat (3) step();
        clr = 1'b1;
        repeat (3) step();

        // 580 us echo after 100 us -> 10 cm, strobe 4 clk after the fall.
        do_arm();
        check("t1_busy", int'(busy), 1);
        echo_meas(100, 580, k);
        check("t1_lat", k, 4);
        check("t1_dist", int'(dist_cm), 10);
        check("t1_flags", int'({no_echo, over_range}), 0);
        count_strobes(1, c1);
        check("t1_one_strobe", c1, 0);

        // Truncation just below centimetre boundaries.
        do_arm();
        echo_meas(10, 57, k);
        check("t2a_lat", k, 4);
        check("t2a_dist", int'(dist_cm), 0);
        repeat (5) step();
        do_arm();
        echo_meas(10, 1159, k);
        check("t2b_dist", int'(dist_cm), 19);

        // No echo: timeout strobe TO*DIV+1 clk after arm.
        repeat (5) step();
        do_arm();
        wait_valid(TO * DIV + 20, k);
        check("t3_lat", k, TO * DIV + 1);
        check("t3_no_echo", int'(no_echo), 1);
        check("t3_dist", int'(dist_cm), 0);
        check("t3_busy", int'(busy), 0);

        // Over-range echo: cut off at MAXUS, later fall ignored.
        repeat (5) step();
        do_arm();
        repeat (20 * DIV) step();
        echo = 1'b1;
        wait_valid(MAXUS * DIV + 20, k);
        check("t4_lat", k, MAXUS * DIV + 4);
        check("t4_dist", int'(dist_cm), MAXUS / UPC);
        check("t4_over", int'(over_range), 1);
        check("t4_no_echo", int'(no_echo), 0);
        repeat (100 * DIV) step();
        echo = 1'b0;
        count_strobes(30, c1);
        check("t4_late_fall", c1, 0);

        // Re-arm while measuring is ignored; idle echo pulse gives no strobe.
        do_arm();
        repeat (20 * DIV) step();
        echo = 1'b1;
        repeat (100 * DIV) step();
        do_arm();
        repeat (1060 * DIV - 1) step();
        echo = 1'b0;
        wait_valid(20, k);
        check("t5_lat", k, 4);
        check("t5_dist", int'(dist_cm), 20);
        check("t5_over", int'(over_range), 0);
        count_strobes(20, c1);
        echo = 1'b1;
        count_strobes(300, c2);
        echo = 1'b0;
        c1 += c2;
        count_strobes(20, c2);
        check("t5_idle_strobes", c1 + c2, 0);

        // Reset mid-measurement clears outputs at once; next measurement is normal.
        do_arm();
        repeat (10 * DIV) step();
        echo = 1'b1;
        repeat (200 * DIV) step();
        clr = 1'b0;
        #1;
        check("t6_rst_dist", int'(dist_cm), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(dist_valid), 0);
        repeat (3) step();
        echo = 1'b0;
        step();
        clr = 1'b1;
        step();
        do_arm();
        echo_meas(20, 290, k);
        check("t6_lat", k, 4);
        check("t6_dist", int'(dist_cm), 5);

        // Randomized traffic, checked by the model only.
        for (int it = 0; it < 12; it++) begin
            pre    = $urandom_range(0, 180);
            w      = (it == 3) ? MAXUS * DIV + 200 : $urandom_range(1, 2100);
            ev_at  = $urandom_range(0, w - 1);
            ex_arm = ($urandom_range(0, 3) == 0);
            do_rst = ($urandom_range(0, 7) == 0);
            idle_p = ($urandom_range(0, 4) == 0);
            if (idle_p) begin
                echo = 1'b1;
                repeat ($urandom_range(1, 60)) step();
                echo = 1'b0;
                repeat (8) step();
            end
            do_arm();
            if (it == 6) begin
                repeat (TO * DIV + 10) step();
            end else begin
                repeat (pre) step();
                echo = 1'b1;
                for (int c = 0; c < w; c++) begin
                    arm = ex_arm && (c == ev_at);
                    clr = !(do_rst && (c == ev_at));
                    step();
                end
                arm  = 1'b0;
                clr  = 1'b1;
                echo = 1'b0;
                repeat (12) step();
            end
        end

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
